decrypt_round: RTL and testbench
================================

# decrypt_round

Single SIMON inverse-round stage for the SIMON64/96 decryption datapath. Takes a 2N-bit ciphertext-side block and one N-bit round key, applies one inverse Feistel round, and presents the result from an output register behind a valid/ready handshake. Cascaded or iterated by the decryption controller, with round keys applied in reverse schedule order (key 41 first for SIMON64/96).

## Interface
- N, default 32: word width; block is 2N bits. Legal: 16, 24, 32, 48, 64.
- clk  input  1  sole clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  in_block/subkey valid this cycle.
- in_ready  output  1  stage can accept input this cycle.
- in_block  input  2N  block entering round; [2N-1:N] = upper word x, [N-1:0] = lower word y.
- subkey  input  N  round key for this round.
- out_valid  output  1  out_block holds a result.
- out_ready  input  1  downstream accepts out_block this cycle.
- out_block  output  2N  block after inverse round, same packing.

## Operation
- f(w) = (rotl(w,1) & rotl(w,8)) ^ rotl(w,2); rotations are circular within N bits.
- Inverse round: out_hi = in_lo; out_lo = in_hi ^ f(in_lo) ^ subkey.
- Pure XOR/AND/rotate; no carries, no width growth; all operands exactly N bits.
- Accept (capture) occurs when in_valid && in_ready; result registered into out_block, out_valid set.
- Output hold: while out_valid && !out_ready, out_block and out_valid are stable; inputs are ignored.
- Inputs sampled only on accept; in_block/subkey changes without in_valid have no effect.

## Timing
- Reset (rst_n low, asynchronous, any time): out_valid = 0, out_block = 0 immediately; in_ready = 1 after release. Transaction in flight at reset is discarded.
- Latency: 1 cycle from accept to out_valid = 1.
- in_ready = !out_valid || out_ready (combinational); throughput 1 block/cycle with out_ready held high.
- Simultaneous output drain and new accept in the same cycle: new result replaces old, out_valid stays 1.
- Drain with no accept: out_valid falls to 0 next cycle; out_block retains last value.
- No combinational path from in_block/subkey to out_block.

## Configuration
- SIMON_ENC_ROUND_EN: when defined, adds input port enc (1 bit, sampled at accept). enc = 1 performs forward round: out_hi = in_hi... specifically out_hi = in_lo ^ f(in_hi) ^ subkey, out_lo = in_hi. enc = 0 performs the inverse round above. When undefined, the port does not exist and the stage always performs the inverse round.

## Test plan
- Known vector (N=32): in_block = 0x5ca2e27f111a8fc8, subkey = 0xb082bddc, in_valid=1, out_ready=1 -> one cycle later out_valid=1, out_block = 0x111a8fc8aa4f6893.
- Zero case: in_block = 0, subkey = 0xdeadbeef -> out_block = 0x00000000deadbeef; subkey = 0 with in_block = 0x00000000ffffffff -> out_block = 0xffffffff_ffffffff ^ f(0xffffffff) applied, i.e. 0xffffffff00000000... verify f(0xffffffff) = 0 so out_block = 0xffffffff00000000.
- Back-pressure: out_ready=0 after first result -> in_ready=0, out_block frozen for 5 cycles despite new in_block; raising out_ready drains and accepts next block same cycle.
- Streaming: 10 consecutive random blocks/keys with out_ready=1 -> 10 results on consecutive cycles, each matching a reference model, no bubbles.
- Reset mid-operation: assert rst_n=0 while out_valid=1 between clock edges -> out_valid and out_block go to 0 before next edge; after release first accepted block produces correct result.
- With SIMON_ENC_ROUND_EN: forward round with enc=1 on 0x111a8fc8aa4f6893 and subkey 0xb082bddc -> out_block = 0x5ca2e27f111a8fc8 (round-trip).

Source files
------------

// File: rtl/decrypt_round.sv
// decrypt_round -- one SIMON inverse-round stage (SIMON64/96 decryption path)
//
// Applies one inverse Feistel round to a 2N-bit block with an N-bit round key:
//   out_hi = in_lo
//   out_lo = in_hi ^ f(in_lo) ^ subkey,  f(w) = (rotl(w,1) & rotl(w,8)) ^ rotl(w,2)
// The result sits in an output register behind a valid/ready handshake.
//
// Optional build macro SIMON_ENC_ROUND_EN adds an 'enc' input. When 'enc' is 1
// at accept, the stage performs the forward round instead:
//   out_hi = in_lo ^ f(in_hi) ^ subkey, out_lo = in_hi
//
// Ports:
//   clk        sole clock, rising edge
//   rst_n      asynchronous active-low reset (clears out_valid and out_block)
//   in_valid   in_block/subkey valid this cycle
//   in_ready   stage can accept this cycle (!out_valid || out_ready)
//   in_block   [2N-1:N] upper word x, [N-1:0] lower word y
//   subkey     round key for this round
//   enc        (SIMON_ENC_ROUND_EN only) 1 = forward round, 0 = inverse round
//   out_valid  out_block holds a result
//   out_ready  downstream accepts out_block this cycle
//   out_block  block after the round, same packing as in_block
module decrypt_round #(
    parameter int N = 32
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [2*N-1:0] in_block,
    input  logic [N-1:0]   subkey,
`ifdef SIMON_ENC_ROUND_EN
    input  logic           enc,
`endif
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*N-1:0] out_block
);

    // Circular left rotation within N bits, done by selecting a window of
    // the word concatenated with itself.
    function automatic logic [N-1:0] rotl(input logic [N-1:0] w, input int s);
        logic [2*N-1:0] dbl;
        dbl = {w, w};
        return dbl[2*N-1-s -: N];
    endfunction

    function automatic logic [N-1:0] roundF(input logic [N-1:0] w);
        return (rotl(w, 1) & rotl(w, 8)) ^ rotl(w, 2);
    endfunction

    logic [N-1:0]   wordHi_p0;
    logic [N-1:0]   wordLo_p0;
    logic [2*N-1:0] nextBlock_p0;
    logic           accept_p0;
    logic [2*N-1:0] block_p1;
    logic           vld_p1;

    assign wordHi_p0 = in_block[2*N-1:N];
    assign wordLo_p0 = in_block[N-1:0];

    // Stage 0: combinational round function on the presented input
    always_comb begin
        nextBlock_p0 = {wordLo_p0, wordHi_p0 ^ roundF(wordLo_p0) ^ subkey};
`ifdef SIMON_ENC_ROUND_EN
        if (enc) begin
            nextBlock_p0 = {wordLo_p0 ^ roundF(wordHi_p0) ^ subkey, wordHi_p0};
        end
`endif
    end

    assign in_ready  = !vld_p1 || out_ready;
    assign accept_p0 = in_valid && in_ready;

    // Stage 1: output register; holds while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1   <= 1'b0;
            block_p1 <= '0;
        end else begin
            if (accept_p0) begin
                vld_p1   <= 1'b1;
                block_p1 <= nextBlock_p0;
            end else if (out_ready) begin
                // Drain without refill: data is kept, only valid drops.
                vld_p1 <= 1'b0;
            end
        end
    end

    assign out_valid = vld_p1;
    assign out_block = block_p1;

endmodule

// File: tb/tb_decrypt_round.sv
// tb_decrypt_round -- directed bench for decrypt_round (N = 32).
module tb_decrypt_round;

    localparam int N = 32;

    logic           clk;
    logic           rst_n;
    logic           in_valid;
    logic           in_ready;
    logic [2*N-1:0] in_block;
    logic [N-1:0]   subkey;
    logic           enc;
    logic           out_valid;
    logic           out_ready;
    logic [2*N-1:0] out_block;

    int checks = 0;
    int errors = 0;

    decrypt_round #(.N(N)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_block  (in_block),
        .subkey    (subkey),
`ifdef SIMON_ENC_ROUND_EN
        .enc       (enc),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_block (out_block)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference round written from the algorithm definition with shifts.
    function automatic logic [31:0] refRotl(input logic [31:0] w, input int s);
        return (w << s) | (w >> (32 - s));
    endfunction

    function automatic logic [63:0] refInv(input logic [63:0] b, input logic [31:0] k);
        logic [31:0] x, y, f;
        x = b[63:32];
        y = b[31:0];
        f = (refRotl(y, 1) & refRotl(y, 8)) ^ refRotl(y, 2);
        return {y, x ^ f ^ k};
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [63:0] expQ [10];
    logic [63:0] rb;
    logic [31:0] rk;

    initial begin
        enc       = 1'b0;
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        in_block  = '0;
        subkey    = '0;
        #1;
        check("reset_out_valid", {63'd0, out_valid}, 64'd0);
        check("reset_out_block", out_block, 64'd0);
        tick();
        tick();
        rst_n = 1'b1;
        #1;
        check("post_reset_in_ready", {63'd0, in_ready}, 64'd1);

        // Known vector
        in_block  = 64'h5ca2e27f111a8fc8;
        subkey    = 32'hb082bddc;
        in_valid  = 1'b1;
        out_ready = 1'b1;
        tick();
        check("known_valid", {63'd0, out_valid}, 64'd1);
        check("known_block", out_block, 64'h111a8fc8aa4f6893);

        // Zero cases
        in_block = 64'h0;
        subkey   = 32'hdeadbeef;
        tick();
        check("zero_block", out_block, 64'h00000000deadbeef);
        in_block = 64'h00000000ffffffff;
        subkey   = 32'h0;
        tick();
        check("ones_block", out_block, 64'hffffffff00000000);
        check("ones_valid", {63'd0, out_valid}, 64'd1);

        // Back-pressure: output frozen, inputs ignored
        out_ready = 1'b0;
        in_block  = 64'h0123456789abcdef;
        subkey    = 32'h13572468;
        #1;
        check("bp_in_ready_low", {63'd0, in_ready}, 64'd0);
        for (int i = 0; i < 5; i++) begin
            in_block = {$urandom, $urandom};
            subkey   = $urandom;
            tick();
            check("bp_hold_block", out_block, 64'hffffffff00000000);
            check("bp_hold_valid", {63'd0, out_valid}, 64'd1);
        end
        in_block  = 64'h5ca2e27f111a8fc8;
        subkey    = 32'hb082bddc;
        out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", {63'd0, in_ready}, 64'd1);
        tick();
        check("bp_replace_block", out_block, 64'h111a8fc8aa4f6893);
        check("bp_replace_valid", {63'd0, out_valid}, 64'd1);

        // Drain with no accept
        in_valid = 1'b0;
        in_block = 64'hffffffffffffffff;
        subkey   = 32'hffffffff;
        tick();
        check("drain_valid", {63'd0, out_valid}, 64'd0);
        check("drain_retain", out_block, 64'h111a8fc8aa4f6893);
        tick();
        check("idle_no_capture", out_block, 64'h111a8fc8aa4f6893);

        // Streaming: one result per cycle
        for (int i = 0; i < 10; i++) begin
            rb       = {$urandom, $urandom};
            rk       = $urandom;
            expQ[i]  = refInv(rb, rk);
            in_block = rb;
            subkey   = rk;
            in_valid = 1'b1;
            tick();
            check("stream_valid", {63'd0, out_valid}, 64'd1);
            check("stream_block", out_block, expQ[i]);
        end
        in_valid = 1'b0;
        tick();

        // Asynchronous reset mid-operation
        in_block = 64'h5ca2e27f111a8fc8;
        subkey   = 32'hb082bddc;
        in_valid = 1'b1;
        tick();
        check("pre_rst_valid", {63'd0, out_valid}, 64'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_valid", {63'd0, out_valid}, 64'd0);
        check("async_rst_block", out_block, 64'd0);
        #2;
        rst_n    = 1'b1;
        in_block = 64'h0;
        subkey   = 32'hdeadbeef;
        tick();
        check("after_rst_block", out_block, 64'h00000000deadbeef);
        check("after_rst_valid", {63'd0, out_valid}, 64'd1);

`ifdef SIMON_ENC_ROUND_EN
        // Forward round undoes the known inverse vector
        enc      = 1'b1;
        in_block = 64'h111a8fc8aa4f6893;
        subkey   = 32'hb082bddc;
        tick();
        check("enc_roundtrip", out_block, 64'h5ca2e27f111a8fc8);
        enc = 1'b0;
`endif

        in_valid = 1'b0;
        tick();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
